// File: rtl/nxn_bit_rr_mux.sv
// nxn_bit_rr_mux: N-input registered selector with valid/ready handshakes.
// Round-robin arbitration by default; force_en selects a fixed channel.
// One output register stage; one transfer per cycle with no pop/push bubble.
module nxn_bit_rr_mux #(
  parameter int width    = 1,
  parameter int inputs   = 5,
  parameter int sel_bits = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [inputs*width-1:0]   in_data,
  input  logic [inputs-1:0]         in_valid,
  output logic [inputs-1:0]         in_ready,
  input  logic                      force_en,
  input  logic [sel_bits-1:0]       force_sel,
  output logic [width-1:0]          out_data,
  output logic [sel_bits-1:0]       out_src,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [width-1:0]    out_data_q, out_data_d;
  logic [sel_bits-1:0] out_src_q,  out_src_d;
  logic                out_valid_q, out_valid_d;
  logic [sel_bits-1:0] last_q,     last_d;

  logic                load;
  logic [inputs-1:0]   grant;
  logic                grant_any;
  logic [sel_bits-1:0] grant_idx;
  logic [width-1:0]    grant_data;

  // Output register may accept new data when empty or being drained.
  always_comb begin
    load = !out_valid_q || out_ready;
  end

  // Grant: forced channel, or first requester after the last winner (cyclic).
  always_comb begin
    int unsigned cand;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    if (force_en) begin
      for (int unsigned i = 0; i < inputs; i++) begin
        if (force_sel == sel_bits'(i) && in_valid[i]) begin
          grant[i]  = 1'b1;
          grant_any = 1'b1;
          grant_idx = sel_bits'(i);
        end
      end
    end else begin
      for (int unsigned k = 1; k <= inputs; k++) begin
        cand = 32'(last_q) + k;
        if (cand >= inputs) cand = cand - inputs;
        for (int unsigned i = 0; i < inputs; i++) begin
          if (!grant_any && i == cand && in_valid[i]) begin
            grant[i]  = 1'b1;
            grant_any = 1'b1;
            grant_idx = sel_bits'(i);
          end
        end
      end
    end
  end

  // Data of the granted channel; zero when nothing is granted.
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < inputs; i++) begin
      if (grant[i]) grant_data = in_data[i*width +: width];
    end
  end

  // Handshake back to producers; suppressed during reset so no transfer is counted.
  always_comb begin
    in_ready = (load && !reset) ? grant : '0;
  end

  // Next-state for the output stage and round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (load) begin
      if (grant_any) begin
        out_data_d  = grant_data;
        out_src_d   = grant_idx;
        out_valid_d = 1'b1;
        last_d      = grant_idx;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset; pointer resets so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      last_q      <= sel_bits'(inputs - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_nxn_bit_rr_mux.sv
// Self-checking bench for nxn_bit_rr_mux: directed scenarios followed by
// randomized traffic, compared against a behavioural reference model.
module tb_nxn_bit_rr_mux;

  localparam int W = 4;
  localparam int N = 5;
  localparam int S = 3;

  logic             clk;
  logic             reset;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic             force_en;
  logic [S-1:0]     force_sel;
  logic [W-1:0]     out_data;
  logic [S-1:0]     out_src;
  logic             out_valid;
  logic             out_ready;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  int       m_last;
  logic     m_ov;
  int       m_od;
  int       m_os;
  logic [N-1:0] m_accepted;

  nxn_bit_rr_mux #(.width(W), .inputs(N), .sel_bits(S)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .force_en(force_en), .force_sel(force_sel),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel picked by the arbitration rules, or -1 if none.
  function automatic int model_grant();
    if (force_en) begin
      if (int'(force_sel) < N) begin
        if (in_valid[force_sel]) return int'(force_sel);
      end
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic int chan_data(input int c);
    logic [N*W-1:0] d;
    d = in_data;
    return int'(d[c*W +: W]);
  endfunction

  // One clock cycle: check outputs/handshake against the model, advance both.
  task automatic step();
    int   g;
    logic ld;
    logic [N-1:0] exp_rdy;
    #2;
    g  = model_grant();
    ld = !m_ov || out_ready;
    exp_rdy = '0;
    if (!reset && ld && g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov || reset) begin
      chk("out_data", 32'(out_data), 32'(m_od));
      chk("out_src", 32'(out_src), 32'(m_os));
    end
    @(posedge clk);
    if (reset) begin
      m_ov = 1'b0; m_od = 0; m_os = 0; m_last = N - 1;
    end else if (ld) begin
      if (g >= 0) begin
        m_od = chan_data(g); m_os = g; m_ov = 1'b1; m_last = g;
      end else begin
        m_ov = 1'b0;
      end
    end
    m_accepted = exp_rdy;
    #1;
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1; in_valid = '0; out_ready = 1'b1; force_en = 1'b0; force_sel = '0;
    in_data = {4'h9, 4'h8, 4'h7, 4'h6, 4'h5};
    @(posedge clk); #1;
    m_ov = 1'b0; m_od = 0; m_os = 0; m_last = N - 1; m_accepted = '0;

    // 1: reset state, nothing valid
    step();
    reset = 1'b0;
    #1;
    chk("t1_in_ready", 32'(in_ready), 32'd0);
    step();

    // 2: all valid, consumer always ready -> grants 0,1,2,3,4,0,...
    reset = 1'b1; step(); reset = 1'b0;
    in_valid = 5'b11111;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("t2_grant", 32'(in_ready), 32'(1 << (i % N)));
      step();
    end
    chk("t2_src", 32'(out_src), 32'd1);

    // 3: sparse requesters with wrap-around, last=4 -> 2,4,2
    reset = 1'b1; in_valid = '0; step(); reset = 1'b0;
    in_valid = 5'b10100;
    #1; chk("t3_g0", 32'(in_ready), 32'b00100); step();
    #1; chk("t3_g1", 32'(in_ready), 32'b10000); step();
    #1; chk("t3_g2", 32'(in_ready), 32'b00100); step();

    // 4: consumer stall for three cycles, then release
    in_valid = 5'b11111;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_hold_data", 32'(out_data), 32'h7);
    end
    out_ready = 1'b1;
    #1; chk("t4_release", 32'(in_ready), 32'b01000);
    step();
    chk("t4_src", 32'(out_src), 32'd3);

    // 5: forced mode on channel 3, then an out-of-range selector
    force_en = 1'b1; force_sel = 3'd3;
    for (int i = 0; i < 3; i++) begin
      #1; chk("t5_force3", 32'(in_ready), 32'b01000);
      step();
    end
    force_sel = 3'd6;
    step();
    step();
    chk("t5_drop", 32'(out_valid), 32'd0);
    force_en = 1'b0;

    // 6: reset while busy and all channels requesting
    step();
    reset = 1'b1;
    step();
    chk("t6_ov", 32'(out_valid), 32'd0);
    #1; chk("t6_rdy", 32'(in_ready), 32'd0);
    step();
    reset = 1'b0;
    #1; chk("t6_first", 32'(in_ready), 32'b00001);
    step();

    // Randomized traffic with legal producers (hold until accepted)
    for (int n = 0; n < 400; n++) begin
      logic [N*W-1:0] d;
      d = in_data;
      for (int c = 0; c < N; c++) begin
        if (m_accepted[c]) in_valid[c] = 1'b0;
        if (!in_valid[c] && ($urandom % 3) == 0) begin
          r = $urandom;
          in_valid[c] = 1'b1;
          d[c*W +: W] = r[W-1:0];
        end
      end
      in_data   = d;
      out_ready = ($urandom % 4) != 0;
      if (($urandom % 16) == 0) force_en = ~force_en;
      r = $urandom;
      force_sel = r[S-1:0];
      reset = ($urandom % 64) == 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
